// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and the execute ALU.
//
// Takes an instruction and its PC over a valid/ready handshake. It reads the
// register file through rs1_addr/rs2_addr and the same-cycle rs1_data/rs2_data,
// and registers an execute bundle one cycle later. The bundle holds the alucode,
// the operands, store data, the branch target, rd and the write/memory enables.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       fetch handshake; in_instr, in_pc are the payload
//   rs1_addr, rs2_addr      regfile read addresses (combinational from in_instr)
//   rs1_data, rs2_data      regfile read data
//   flush                   kill the held bundle and any same-cycle accept
//   out_valid/out_ready     execute handshake
//   alucode, op1, op2       ALU operation and operands
//   store_data, br_target   rs2 value for stores, branch/jump target
//   rd_addr, reg_we         destination register and writeback enable
//   mem_re, mem_we          load / store
//   out_pc                  PC of the bundle (RESET_PC while in reset)
//   illegal                 only with DECODE_ILLEGAL_TRAP_EN: the bundle came from
//                           an illegal encoding
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN adds the registered illegal output.
// Illegal encodings always decode as a NOP (ALU_ADD, zero operands, no enables).

module decode_stage #(
   parameter int unsigned XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      alucode,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [XLEN-1:0] store_data,
   output logic [XLEN-1:0] br_target,
   output logic [4:0]      rd_addr,
   output logic            reg_we,
   output logic            mem_re,
   output logic            mem_we,
`ifdef DECODE_ILLEGAL_TRAP_EN
   output logic            illegal,
`endif
   output logic [XLEN-1:0] out_pc
);

   // ALU operation encodings shared with the execute stage
   localparam logic [5:0] ALU_LUI  = 6'd0;
   localparam logic [5:0] ALU_JAL  = 6'd1;
   localparam logic [5:0] ALU_JALR = 6'd2;
   localparam logic [5:0] ALU_BEQ  = 6'd3;
   localparam logic [5:0] ALU_BNE  = 6'd4;
   localparam logic [5:0] ALU_BLT  = 6'd5;
   localparam logic [5:0] ALU_BGE  = 6'd6;
   localparam logic [5:0] ALU_BLTU = 6'd7;
   localparam logic [5:0] ALU_BGEU = 6'd8;
   localparam logic [5:0] ALU_LB   = 6'd9;
   localparam logic [5:0] ALU_LH   = 6'd10;
   localparam logic [5:0] ALU_LW   = 6'd11;
   localparam logic [5:0] ALU_LBU  = 6'd12;
   localparam logic [5:0] ALU_LHU  = 6'd13;
   localparam logic [5:0] ALU_SB   = 6'd14;
   localparam logic [5:0] ALU_SH   = 6'd15;
   localparam logic [5:0] ALU_SW   = 6'd16;
   localparam logic [5:0] ALU_ADD  = 6'd17;
   localparam logic [5:0] ALU_SUB  = 6'd18;
   localparam logic [5:0] ALU_XOR  = 6'd19;
   localparam logic [5:0] ALU_OR   = 6'd20;
   localparam logic [5:0] ALU_AND  = 6'd21;
   localparam logic [5:0] ALU_SLL  = 6'd22;
   localparam logic [5:0] ALU_SRL  = 6'd23;
   localparam logic [5:0] ALU_SRA  = 6'd24;
   localparam logic [5:0] ALU_SLT  = 6'd25;
   localparam logic [5:0] ALU_SLTU = 6'd26;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign rd     = in_instr[11:7];

   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
   assign shamt = {27'b0, in_instr[24:20]};

   logic [5:0]      dec_alucode;
   logic [XLEN-1:0] dec_op1, dec_op2, dec_store_data, dec_br_target;
   logic            dec_writes_rd, dec_mem_re, dec_mem_we, dec_illegal;
   logic [4:0]      dec_rd_addr;
   logic            dec_reg_we;
   logic            accept;

   always_comb begin
      dec_alucode    = ALU_ADD;
      dec_op1        = '0;
      dec_op2        = '0;
      dec_store_data = '0;
      dec_br_target  = '0;
      dec_writes_rd  = 1'b0;
      dec_mem_re     = 1'b0;
      dec_mem_we     = 1'b0;
      dec_illegal    = 1'b0;

      unique case (opcode)
         OP_LUI: begin
            dec_alucode   = ALU_LUI;
            dec_op2       = imm_u;
            dec_writes_rd = 1'b1;
         end
         OP_AUIPC: begin
            dec_op1       = in_pc;
            dec_op2       = imm_u;
            dec_writes_rd = 1'b1;
         end
         OP_JAL: begin
            dec_alucode   = ALU_JAL;
            dec_op2       = in_pc;
            dec_br_target = in_pc + imm_j;
            dec_writes_rd = 1'b1;
         end
         OP_JALR: begin
            dec_alucode   = ALU_JALR;
            dec_op2       = in_pc;
            dec_br_target = (rs1_data + imm_i) & ~32'd1;
            dec_writes_rd = 1'b1;
            dec_illegal   = (funct3 != 3'b000);
         end
         OP_BRANCH: begin
            dec_op1       = rs1_data;
            dec_op2       = rs2_data;
            dec_br_target = in_pc + imm_b;
            case (funct3)
               3'b000:  dec_alucode = ALU_BEQ;
               3'b001:  dec_alucode = ALU_BNE;
               3'b100:  dec_alucode = ALU_BLT;
               3'b101:  dec_alucode = ALU_BGE;
               3'b110:  dec_alucode = ALU_BLTU;
               3'b111:  dec_alucode = ALU_BGEU;
               default: dec_illegal = 1'b1;
            endcase
         end
         OP_LOAD: begin
            dec_op1       = rs1_data;
            dec_op2       = imm_i;
            dec_mem_re    = 1'b1;
            dec_writes_rd = 1'b1;
            case (funct3)
               3'b000:  dec_alucode = ALU_LB;
               3'b001:  dec_alucode = ALU_LH;
               3'b010:  dec_alucode = ALU_LW;
               3'b100:  dec_alucode = ALU_LBU;
               3'b101:  dec_alucode = ALU_LHU;
               default: dec_illegal = 1'b1;
            endcase
         end
         OP_STORE: begin
            dec_op1        = rs1_data;
            dec_op2        = imm_s;
            dec_store_data = rs2_data;
            dec_mem_we     = 1'b1;
            case (funct3)
               3'b000:  dec_alucode = ALU_SB;
               3'b001:  dec_alucode = ALU_SH;
               3'b010:  dec_alucode = ALU_SW;
               default: dec_illegal = 1'b1;
            endcase
         end
         OP_IMM: begin
            dec_op1       = rs1_data;
            dec_op2       = imm_i;
            dec_writes_rd = 1'b1;
            case (funct3)
               3'b000: dec_alucode = ALU_ADD;
               3'b010: dec_alucode = ALU_SLT;
               3'b011: dec_alucode = ALU_SLTU;
               3'b100: dec_alucode = ALU_XOR;
               3'b110: dec_alucode = ALU_OR;
               3'b111: dec_alucode = ALU_AND;
               3'b001: begin
                  dec_alucode = ALU_SLL;
                  dec_op2     = shamt;
                  dec_illegal = (funct7 != F7_ZERO);
               end
               default: begin // 3'b101: SRLI / SRAI
                  dec_op2 = shamt;
                  if (funct7 == F7_ZERO)     dec_alucode = ALU_SRL;
                  else if (funct7 == F7_ALT) dec_alucode = ALU_SRA;
                  else                       dec_illegal = 1'b1;
               end
            endcase
         end
         OP_OP: begin
            dec_op1       = rs1_data;
            dec_op2       = rs2_data;
            dec_writes_rd = 1'b1;
            if (funct7 == F7_ZERO) begin
               case (funct3)
                  3'b000:  dec_alucode = ALU_ADD;
                  3'b001:  dec_alucode = ALU_SLL;
                  3'b010:  dec_alucode = ALU_SLT;
                  3'b011:  dec_alucode = ALU_SLTU;
                  3'b100:  dec_alucode = ALU_XOR;
                  3'b101:  dec_alucode = ALU_SRL;
                  3'b110:  dec_alucode = ALU_OR;
                  default: dec_alucode = ALU_AND;
               endcase
            end else if (funct7 == F7_ALT) begin
               case (funct3)
                  3'b000:  dec_alucode = ALU_SUB;
                  3'b101:  dec_alucode = ALU_SRA;
                  default: dec_illegal = 1'b1;
               endcase
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OP_FENCE: ; // NOP: defaults already describe it
         default: dec_illegal = 1'b1; // includes SYSTEM
      endcase

      // Illegal encodings collapse to the NOP bundle
      if (dec_illegal) begin
         dec_alucode    = ALU_ADD;
         dec_op1        = '0;
         dec_op2        = '0;
         dec_store_data = '0;
         dec_br_target  = '0;
         dec_writes_rd  = 1'b0;
         dec_mem_re     = 1'b0;
         dec_mem_we     = 1'b0;
      end
   end

   // rd is reported only for instructions that actually write a non-zero register
   assign dec_reg_we  = dec_writes_rd && (rd != 5'd0);
   assign dec_rd_addr = dec_reg_we ? rd : 5'd0;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         alucode    <= '0;
         op1        <= '0;
         op2        <= '0;
         store_data <= '0;
         br_target  <= '0;
         rd_addr    <= '0;
         reg_we     <= 1'b0;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
         out_pc     <= RESET_PC;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         alucode    <= dec_alucode;
         op1        <= dec_op1;
         op2        <= dec_op2;
         store_data <= dec_store_data;
         br_target  <= dec_br_target;
         rd_addr    <= dec_rd_addr;
         reg_we     <= dec_reg_we;
         mem_re     <= dec_mem_re;
         mem_we     <= dec_mem_we;
         out_pc     <= in_pc;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal <= 1'b0;
      end else if (!flush && accept) begin
         illegal <= dec_illegal;
      end
   end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-computed bundles,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_decode_stage;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   localparam logic [5:0] ALU_LUI  = 6'd0;
   localparam logic [5:0] ALU_JAL  = 6'd1;
   localparam logic [5:0] ALU_JALR = 6'd2;
   localparam logic [5:0] ALU_BEQ  = 6'd3;
   localparam logic [5:0] ALU_LW   = 6'd11;
   localparam logic [5:0] ALU_SW   = 6'd16;
   localparam logic [5:0] ALU_ADD  = 6'd17;
   localparam logic [5:0] ALU_SUB  = 6'd18;
   localparam logic [5:0] ALU_SRA  = 6'd24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [5:0]  alucode;
   logic [31:0] op1, op2, store_data, br_target, out_pc;
   logic [4:0]  rd_addr;
   logic        reg_we, mem_re, mem_we;
   logic        ill_act;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        illegal;
   assign ill_act = illegal;
`else
   assign ill_act = 1'b0;
`endif

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .alucode(alucode), .op1(op1), .op2(op2),
      .store_data(store_data), .br_target(br_target), .rd_addr(rd_addr),
      .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
`ifdef DECODE_ILLEGAL_TRAP_EN
      .illegal(illegal),
`endif
      .out_pc(out_pc)
   );

   typedef struct {
      string       name;
      logic [5:0]  alu;
      logic [31:0] op1, op2, sd, br;
      logic [4:0]  rd;
      logic        we, re, mwe;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic exp_t mk(string name, logic [5:0] alu, logic [31:0] a, logic [31:0] b,
                               logic [31:0] sd, logic [31:0] br, logic [4:0] rd,
                               logic we, logic re, logic mwe, logic [31:0] pc, logic ill);
      exp_t e;
      e.name = name; e.alu = alu; e.op1 = a; e.op2 = b; e.sd = sd; e.br = br;
      e.rd = rd; e.we = we; e.re = re; e.mwe = mwe; e.pc = pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.ill = ill;
`else
      e.ill = 1'b0 & ill;
`endif
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: one comparison per transferred bundle
   exp_t e;
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_bundle: got alucode=%0d pc=%h expected no bundle",
                     alucode, out_pc);
         end else begin
            e = sb.pop_front();
            if (alucode !== e.alu || op1 !== e.op1 || op2 !== e.op2 || store_data !== e.sd ||
                br_target !== e.br || rd_addr !== e.rd || reg_we !== e.we ||
                mem_re !== e.re || mem_we !== e.mwe || out_pc !== e.pc || ill_act !== e.ill) begin
               failures++;
               $display({"FAIL %s: got alu=%0d op1=%h op2=%h sd=%h br=%h rd=%0d we=%b re=%b ",
                         "mwe=%b pc=%h ill=%b expected alu=%0d op1=%h op2=%h sd=%h br=%h ",
                         "rd=%0d we=%b re=%b mwe=%b pc=%h ill=%b"},
                        e.name, alucode, op1, op2, store_data, br_target, rd_addr, reg_we,
                        mem_re, mem_we, out_pc, ill_act, e.alu, e.op1, e.op2, e.sd, e.br,
                        e.rd, e.we, e.re, e.mwe, e.pc, e.ill);
            end
         end
      end
   end

   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input exp_t ex);
      in_instr = instr; in_pc = pc; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
      sb.push_back(ex);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      rs1_data = '0; rs2_data = '0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_out_pc", out_pc, RST_PC);
      chk("reset_alucode", {26'b0, alucode}, 32'd0);
      chk("reset_op2", op2, 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset_ill", {31'b0, ill_act}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Back-to-back directed vectors
      send(32'h00500093, 32'h0, 32'd0, 32'd0,
           mk("addi", ALU_ADD, 32'd0, 32'd5, 32'd0, 32'd0, 5'd1, 1, 0, 0, 32'h0, 0));
      send(32'h402081B3, 32'h4, 32'd10, 32'd3,
           mk("sub", ALU_SUB, 32'd10, 32'd3, 32'd0, 32'd0, 5'd3, 1, 0, 0, 32'h4, 0));
      send(32'h00208463, 32'h100, 32'd7, 32'd7,
           mk("beq", ALU_BEQ, 32'd7, 32'd7, 32'd0, 32'h108, 5'd0, 0, 0, 0, 32'h100, 0));
      send(32'h123452B7, 32'h10, 32'd0, 32'd0,
           mk("lui", ALU_LUI, 32'd0, 32'h12345000, 32'd0, 32'd0, 5'd5, 1, 0, 0, 32'h10, 0));
      send(32'h00001317, 32'h200, 32'd0, 32'd0,
           mk("auipc", ALU_ADD, 32'h200, 32'h1000, 32'd0, 32'd0, 5'd6, 1, 0, 0, 32'h200, 0));
      send(32'hFFDFF0EF, 32'h300, 32'd0, 32'd0,
           mk("jal", ALU_JAL, 32'd0, 32'h300, 32'd0, 32'h2FC, 5'd1, 1, 0, 0, 32'h300, 0));
      send(32'h00310067, 32'h400, 32'h1000, 32'd0,
           mk("jalr", ALU_JALR, 32'd0, 32'h400, 32'd0, 32'h1002, 5'd0, 0, 0, 0, 32'h400, 0));
      send(32'hFF80A283, 32'h20, 32'h2000, 32'd0,
           mk("lw", ALU_LW, 32'h2000, 32'hFFFFFFF8, 32'd0, 32'd0, 5'd5, 1, 1, 0, 32'h20, 0));
      send(32'h0020A623, 32'h24, 32'h3000, 32'hDEADBEEF,
           mk("sw", ALU_SW, 32'h3000, 32'd12, 32'hDEADBEEF, 32'd0, 5'd0, 0, 0, 1, 32'h24, 0));
      send(32'h4041D393, 32'h28, 32'h80000000, 32'd0,
           mk("srai", ALU_SRA, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd7, 1, 0, 0, 32'h28, 0));
      send(32'h00100013, 32'h2C, 32'd0, 32'd0,
           mk("addi_x0", ALU_ADD, 32'd0, 32'd1, 32'd0, 32'd0, 5'd0, 0, 0, 0, 32'h2C, 0));
      send(32'h0FF0000F, 32'h30, 32'd0, 32'd0,
           mk("fence", ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 32'h30, 0));
      send(32'hFFFFFFFF, 32'h34, 32'h55, 32'h66,
           mk("all_ones", ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 32'h34, 1));
      send(32'h02009093, 32'h38, 32'h55, 32'd0,
           mk("slli_bad_f7", ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 32'h38, 1));
      send(32'h00000073, 32'h3C, 32'd0, 32'd0,
           mk("ecall", ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 32'h3C, 1));
      repeat (2) @(posedge clk); #1;

      // Back-pressure: hold ADDI x2 while ADD x4,x1,x2 waits
      in_instr = 32'h00700113; in_pc = 32'h40; rs1_data = 32'd0; rs2_data = 32'd0;
      in_valid = 1'b1;
      sb.push_back(mk("stall_addi", ALU_ADD, 32'd0, 32'd7, 32'd0, 32'd0, 5'd2, 1, 0, 0,
                      32'h40, 0));
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_instr = 32'h00208233; in_pc = 32'h44; rs1_data = 32'd1; rs2_data = 32'd2;
      sb.push_back(mk("stall_add", ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4, 1, 0, 0,
                      32'h44, 0));
      repeat (2) begin
         @(negedge clk);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_op2_held", op2, 32'd7);
         chk("stall_rd_held", {27'b0, rd_addr}, 32'd2);
         chk("stall_pc_held", out_pc, 32'h40);
         chk("rs_addr_comb", {22'b0, rs1_addr, rs2_addr}, {22'b0, 5'd1, 5'd2});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Flush coincident with accept of LW x5,0(x1): LW must never appear
      in_instr = 32'h0000A283; in_pc = 32'h50; rs1_data = 32'h100; in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_accept_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;

      // Flush kills a held bundle
      out_ready = 1'b0;
      in_instr = 32'h00100493; in_pc = 32'h60; rs1_data = 32'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("held_before_flush", {31'b0, out_valid}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_held_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;

      // Illegal word held under stall, then async reset mid-stall
      in_instr = 32'hFFFFFFFF; in_pc = 32'h500; rs1_data = 32'h9; rs2_data = 32'h9;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("ill_valid", {31'b0, out_valid}, 32'd1);
      chk("ill_alucode", {26'b0, alucode}, {26'b0, ALU_ADD});
      chk("ill_reg_we", {31'b0, reg_we}, 32'd0);
      chk("ill_op1", op1, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("ill_flag", {31'b0, illegal}, 32'd1);
`endif
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("async_rst_pc", out_pc, RST_PC);
      chk("async_rst_ill", {31'b0, ill_act}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
